mul_seq_nbits: RTL
==================

// Module: mul_seq_nbits
// PURPOSE
//   Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
//   Sequential successor to the combinational 8-bit multiplier: start/busy/done handshake, one partial product per clock.
//   Serves as the multiply unit of the datapath/ALU wherever area matters more than single-cycle latency.
// PARAMETERS
//   WIDTH   8   operand width in bits (>=2); product width is 2*WIDTH
// PORTS
//   clk     in   1          single clock, all state updates on posedge
//   rst     in   1          synchronous, active-high reset
//   start   in   1          request; sampled only while idle (busy=0)
//   A       in   WIDTH      multiplicand, sampled with accepted start
//   B       in   WIDTH      multiplier, sampled with accepted start
//   Signed  in   1          1: A,B two's complement; 0: unsigned; sampled with accepted start
//   busy    out  1          high from accept edge until result edge
//   done    out  1          one-cycle pulse, result valid on Prod
//   Prod    out  2*WIDTH    product; holds last result until next done
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, Prod=0, counter=0; overrides any operation in flight.
//   FSM states IDLE, CALC, FIN (shared enum).
//   IDLE: start=1 at edge k -> latch |A|,|B| (magnitudes if Signed, else raw), neg=Signed&(A[W-1]^B[W-1]);
//     acc=0, cnt=0, busy=1, -> CALC. start=0: stay, busy=0.
//   CALC: per edge, if mplr[0] acc+=mcand<<cnt (2*WIDTH-bit add, no carry loss); mplr>>=1; cnt++;
//     after WIDTH edges -> FIN.
//   FIN: Prod <= neg ? -acc : acc (2*WIDTH two's complement), done=1, busy=0, -> IDLE.
//   Latency: done high in cycle following edge k+WIDTH+1; throughput one op per WIDTH+2 cycles.
//   done is a registered 1-cycle pulse; cleared on the next edge.
//   start asserted while busy=1: ignored, no queueing; operands/Signed changes mid-op have no effect.
//   start asserted in the cycle done=1: accepted (FSM already IDLE) -> back-to-back ops.
//   Edge: magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), representable in WIDTH unsigned bits; no special case.
//   Edge: A=0 or B=0 -> Prod=0 after full latency (no early exit), neg irrelevant since -0=0.
//   Signed=0: A,B pass raw, neg=0.
// CONFIGURATION
//   MUL_SEQ_OVF_EN defined: extra output ovf (1 bit), registered at FIN with Prod, reset 0, holds with Prod.
//     Unsigned: ovf = |Prod[2W-1:W]. Signed: ovf = Prod[2W-1:W-1] not all equal (result not in WIDTH bits).
//   MUL_SEQ_OVF_EN undefined: ovf port and logic absent; all other behaviour identical.
// STRUCTURE
//   Shared package mul_pkg: FSM state encoding (IDLE/CALC/FIN) and state width; counter width = $clog2(WIDTH+1).
//   Sub-module mul_abs_conv (WIDTH param): conditional two's-complement negate (en ? -x : x);
//     instantiated twice for operand magnitudes, once at 2*WIDTH for result sign.
// TESTING  (WIDTH=8 unless noted)
//   1. A=3, B=5, Signed=0 -> done after 9 cycles, Prod=16'h000F, busy high for exactly 9 cycles.
//   2. A=-3, B=-5, Signed=1 -> Prod=16'h000F; A=-3, B=5 -> 16'hFFF1; A=5, B=-3 -> 16'hFFF1.
//   3. A=8'hFF, B=8'hFF: Signed=0 -> 16'hFE01; Signed=1 -> 16'h0001; A=B=8'h80 Signed=1 -> 16'h4000.
//   4. start pulsed mid-CALC with A=7, B=7 -> ignored; first result unchanged; no extra done pulse.
//   5. rst asserted 3 cycles into CALC -> next cycle busy=0, done=0, Prod=0; new start then runs normally.
//   6. start held high across done -> back-to-back results; MUL_SEQ_OVF_EN: 16*16 unsigned ovf=1, 10*12 ovf=0;
//      WIDTH=16 random signed/unsigned sweep vs behavioural reference product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mul_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // The counter must be able to hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_abs_conv.sv
// Conditional two's-complement negate: y = en ? -x : x.
// Used for operand magnitudes and for applying the result sign.
module mul_abs_conv #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Negating the most negative value wraps to itself, which is exactly its
  // magnitude when the result is read as unsigned.
  assign y = en ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/mul_seq_nbits.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation, one partial product per clock.
// Optional build macro MUL_SEQ_OVF_EN adds an 'ovf' output flagging a
// product that does not fit back into WIDTH bits.
module mul_seq_nbits
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Signed,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Prod
`ifdef MUL_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [PW-1:0]      prod_fin;

`ifdef MUL_SEQ_OVF_EN
  logic               sgn_q, sgn_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH:0]     prod_top;
`endif

  // Operand magnitudes; a negative operand is only negated for signed ops.
  mul_abs_conv #(.WIDTH(WIDTH)) u_abs_a (
    .en (Signed & A[WIDTH-1]),
    .x  (A),
    .y  (a_mag)
  );

  mul_abs_conv #(.WIDTH(WIDTH)) u_abs_b (
    .en (Signed & B[WIDTH-1]),
    .x  (B),
    .y  (b_mag)
  );

  // Re-applies the sign to the unsigned magnitude product.
  mul_abs_conv #(.WIDTH(PW)) u_sign_res (
    .en (neg_q),
    .x  (acc_q),
    .y  (prod_fin)
  );

`ifdef MUL_SEQ_OVF_EN
  // Signed result fits in WIDTH bits only if its top WIDTH+1 bits agree.
  assign prod_top = prod_fin[PW-1:WIDTH-1];
`endif

  // Next-state logic: operand capture, one shift-add step per CALC cycle,
  // sign fix-up and result publish in FIN.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
`ifdef MUL_SEQ_OVF_EN
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          neg_d   = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MUL_SEQ_OVF_EN
          sgn_d   = Signed;
`endif
        end
      end

      CALC: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        end
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end

      FIN: begin
        prod_d  = prod_fin;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef MUL_SEQ_OVF_EN
        ovf_d   = sgn_q ? ~((&prod_top) | ~(|prod_top))
                        : (|prod_fin[PW-1:WIDTH]);
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      done_q  <= 1'b0;
`ifdef MUL_SEQ_OVF_EN
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
`ifdef MUL_SEQ_OVF_EN
      sgn_q   <= sgn_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign Prod = prod_q;
`ifdef MUL_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
